// File: rtl/rx_recv.sv
// rx_recv: receive-side parser for the Metis host protocol.
// It decodes data frames (EF FE 01 <ep> <seq32> <payload>) into FIFO writes.
// It decodes start/stop frames (EF FE 04 <cmd>) into run / wide_spectrum.
// It turns discovery frames (EF FE 02) into a held request for the sender.
// Optional build macro RX_SEQ_CHECK_EN enables data-frame sequence checking,
// which drives seq_err_count; without it seq_err_count is tied to 0.
module rx_recv #(
  parameter int          PAYLOAD_BYTES = 1024,
  parameter logic [7:0]  DATA_EP       = 8'h02
) (
  input  logic       rx_clock,
  input  logic       Rx_reset,
  input  logic       udp_rx_active,
  input  logic [7:0] udp_rx_data,
  input  logic       fifo_full,
  output logic       fifo_wrreq,
  output logic [7:0] fifo_wrdata,
  output logic       run,
  output logic       wide_spectrum,
  output logic       discovery,
  input  logic       discovery_ack,
  output logic       fifo_overflow,
  output logic       runt_pkt,
  output logic [7:0] seq_err_count
);

  typedef enum logic [2:0] {
    IDLE, HDR_FE, TYPE, EP_CMD, SEQ, PAYLOAD, DRAIN
  } state_t;

  localparam logic [10:0] LAST_BYTE = 11'(PAYLOAD_BYTES - 1);

  state_t      state_reg;
  logic        is_data_reg;
  logic [10:0] byte_cnt_reg;
  // Set by reset so that a datagram already in flight is drained, not parsed
  logic        post_reset_reg;

  logic disc_set;
  logic cmd_take;
  logic run_next;
  logic run_rise;

  assign disc_set = (state_reg == TYPE) && udp_rx_active && (udp_rx_data == 8'h02);
  assign cmd_take = (state_reg == EP_CMD) && udp_rx_active && !is_data_reg;
  assign run_next = cmd_take ? udp_rx_data[0] : run;
  assign run_rise = run_next && !run;

  // Frame parser, FIFO write path, command latches and error flags
  always_ff @(posedge rx_clock or posedge Rx_reset) begin
    if (Rx_reset) begin
      state_reg      <= IDLE;
      is_data_reg    <= 1'b0;
      byte_cnt_reg   <= 11'd0;
      post_reset_reg <= 1'b1;
      fifo_wrreq     <= 1'b0;
      fifo_wrdata    <= 8'd0;
      run            <= 1'b0;
      wide_spectrum  <= 1'b0;
      fifo_overflow  <= 1'b0;
      runt_pkt       <= 1'b0;
    end else begin
      fifo_wrreq     <= 1'b0;
      runt_pkt       <= 1'b0;
      post_reset_reg <= 1'b0;
      if (!udp_rx_active) begin
        // End of datagram always resynchronises; a short data frame is flagged
        state_reg <= IDLE;
        if (state_reg == SEQ || state_reg == PAYLOAD) begin
          runt_pkt <= 1'b1;
        end
      end else begin
        case (state_reg)
          IDLE: begin
            if (!post_reset_reg && udp_rx_data == 8'hEF) begin
              state_reg <= HDR_FE;
            end else begin
              state_reg <= DRAIN;
            end
          end
          HDR_FE: begin
            state_reg <= (udp_rx_data == 8'hFE) ? TYPE : DRAIN;
          end
          TYPE: begin
            case (udp_rx_data)
              8'h01: begin
                is_data_reg <= 1'b1;
                state_reg   <= EP_CMD;
              end
              8'h04: begin
                is_data_reg <= 1'b0;
                state_reg   <= EP_CMD;
              end
              default: state_reg <= DRAIN;
            endcase
          end
          EP_CMD: begin
            if (is_data_reg) begin
              if (udp_rx_data == DATA_EP) begin
                byte_cnt_reg <= 11'd0;
                state_reg    <= SEQ;
              end else begin
                state_reg <= DRAIN;
              end
            end else begin
              run           <= udp_rx_data[0];
              wide_spectrum <= udp_rx_data[1];
              if (run_rise) begin
                fifo_overflow <= 1'b0;
              end
              state_reg <= DRAIN;
            end
          end
          SEQ: begin
            if (byte_cnt_reg == 11'd3) begin
              byte_cnt_reg <= 11'd0;
              state_reg    <= PAYLOAD;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 11'd1;
            end
          end
          PAYLOAD: begin
            if (!fifo_full) begin
              fifo_wrreq  <= 1'b1;
              fifo_wrdata <= udp_rx_data;
            end else begin
              fifo_overflow <= 1'b1;
            end
            if (byte_cnt_reg == LAST_BYTE) begin
              state_reg <= DRAIN;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 11'd1;
            end
          end
          default: state_reg <= DRAIN;  // DRAIN: wait for end of datagram
        endcase
      end
    end
  end

  // Held discovery request; a new request wins over a same-cycle acknowledge
  always_ff @(posedge rx_clock or posedge Rx_reset) begin
    if (Rx_reset) begin
      discovery <= 1'b0;
    end else if (disc_set) begin
      discovery <= 1'b1;
    end else if (discovery_ack) begin
      discovery <= 1'b0;
    end
  end

`ifdef RX_SEQ_CHECK_EN
  logic [23:0] seq_shift_reg;
  logic [31:0] seq_expected_reg;
  logic        seq_valid_reg;
  logic [7:0]  seq_err_reg;
  logic [31:0] seq_received;
  logic        seq_done;
  logic        run_fall;

  assign seq_received = {seq_shift_reg, udp_rx_data};
  assign seq_done     = (state_reg == SEQ) && udp_rx_active && (byte_cnt_reg == 11'd3);
  assign run_fall     = !run_next && run;

  // Sequence tracker: compare against received+1 of the previous frame
  always_ff @(posedge rx_clock or posedge Rx_reset) begin
    if (Rx_reset) begin
      seq_shift_reg    <= 24'd0;
      seq_expected_reg <= 32'd0;
      seq_valid_reg    <= 1'b0;
      seq_err_reg      <= 8'd0;
    end else begin
      if (state_reg == SEQ && udp_rx_active) begin
        seq_shift_reg <= seq_received[23:0];
      end
      if (run_rise || run_fall) begin
        seq_valid_reg <= 1'b0;
      end else if (seq_done) begin
        if (seq_valid_reg && seq_received != seq_expected_reg && seq_err_reg != 8'hFF) begin
          seq_err_reg <= seq_err_reg + 8'd1;
        end
        seq_expected_reg <= seq_received + 32'd1;
        seq_valid_reg    <= 1'b1;
      end
    end
  end

  assign seq_err_count = seq_err_reg;
`else
  assign seq_err_count = 8'd0;
`endif

endmodule
